// File: rtl/audio_peak_meter.sv
// audio_peak_meter
//   Per-channel peak detector with hold and linear decay. Signed 16-bit
//   left/right samples are turned into unsigned 16-bit envelope magnitudes
//   (full scale 16'hFFFE) for the LED level display.
//
//   Parameters
//     HOLD_SAMPLES : samples a fresh peak is held before decay (1..65535)
//     DECAY_STEP   : amount removed from the peak per sample while decaying
//
//   Ports
//     clk, rst     : clock, asynchronous active-high reset
//     smpl_vld     : single-cycle strobe qualifying lft_in / rht_in
//     lft_in/rht_in: signed two's-complement samples
//     lft_out/rht_out : envelope, updated the cycle after smpl_vld
//     peak_vld     : one-cycle pulse, one cycle after each smpl_vld
//
//   Build option
//     PEAK_STEREO_LINK_EN : when defined, one FSM tracks max(mag_l, mag_r)
//                           and drives both outputs.

module peak_chan #(
  parameter int unsigned HOLD_SAMPLES = 4800,
  parameter logic [15:0] DECAY_STEP   = 16'h0040
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        smpl_vld,
  input  logic [15:0] mag,
  output logic [15:0] peak
);
  typedef enum logic [1:0] {IDLE, HOLD, DECAY} state_t;

  // The counter is loaded with the full hold length: after a capture,
  // HOLD_SAMPLES lower samples keep the peak, the next one moves to DECAY
  // and the one after that applies the first decrement.
  localparam logic [15:0] HOLD_LOAD = 16'(HOLD_SAMPLES);

  state_t      state_q, state_d;
  logic [15:0] peak_q, peak_d;
  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic [16:0] diff;
  logic [15:0] dec;

  // Borrow out of the 17-bit subtraction clamps the decayed peak to 0.
  assign diff = {1'b0, peak_q} - {1'b0, DECAY_STEP};
  assign dec  = diff[16] ? 16'h0000 : diff[15:0];

  always_comb begin
    state_d    = state_q;
    peak_d     = peak_q;
    hold_cnt_d = hold_cnt_q;
    if (smpl_vld) begin
      // Zero never captures, so IDLE always means peak == 0.
      if (mag >= peak_q && mag != 16'h0000) begin
        peak_d     = mag;
        hold_cnt_d = HOLD_LOAD;
        state_d    = HOLD;
      end else begin
        case (state_q)
          HOLD: begin
            if (hold_cnt_q != 16'h0000) hold_cnt_d = hold_cnt_q - 16'h0001;
            else                        state_d    = DECAY;
          end
          DECAY: begin
            if (mag >= dec && mag != 16'h0000) begin
              peak_d     = mag;
              hold_cnt_d = HOLD_LOAD;
              state_d    = HOLD;
            end else begin
              peak_d = dec;
              if (dec == 16'h0000) state_d = IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      peak_q     <= 16'h0000;
      hold_cnt_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      peak_q     <= peak_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // The peak register is the output register: one cycle of latency.
  assign peak = peak_q;
endmodule

module audio_peak_meter #(
  parameter int unsigned HOLD_SAMPLES = 4800,
  parameter logic [15:0] DECAY_STEP   = 16'h0040
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        smpl_vld,
  input  logic [15:0] lft_in,
  input  logic [15:0] rht_in,
  output logic [15:0] lft_out,
  output logic [15:0] rht_out,
  output logic        peak_vld
);
  // min(|x|, 7FFF) << 1 ; -32768 negates to 8000 and saturates to FFFE.
  function automatic logic [15:0] to_mag(input logic [15:0] x);
    logic [15:0] a;
    a = x[15] ? (~x + 16'h0001) : x;
    if (a > 16'h7FFF) a = 16'h7FFF;
    return {a[14:0], 1'b0};
  endfunction

  logic [15:0] mag_l, mag_r;
  logic        peak_vld_q, peak_vld_d;

  assign mag_l = to_mag(lft_in);
  assign mag_r = to_mag(rht_in);

`ifdef PEAK_STEREO_LINK_EN
  logic [15:0] mag_link;
  logic [15:0] peak_link;
  assign mag_link = (mag_l > mag_r) ? mag_l : mag_r;

  peak_chan #(.HOLD_SAMPLES(HOLD_SAMPLES), .DECAY_STEP(DECAY_STEP)) u_link (
    .clk(clk), .rst(rst), .smpl_vld(smpl_vld), .mag(mag_link), .peak(peak_link)
  );
  assign lft_out = peak_link;
  assign rht_out = peak_link;
`else
  logic [1:0][15:0] mag_ch, peak_ch;
  assign mag_ch = {mag_r, mag_l};

  for (genvar g = 0; g < 2; g++) begin : g_ch
    peak_chan #(.HOLD_SAMPLES(HOLD_SAMPLES), .DECAY_STEP(DECAY_STEP)) u_chan (
      .clk(clk), .rst(rst), .smpl_vld(smpl_vld), .mag(mag_ch[g]), .peak(peak_ch[g])
    );
  end
  assign lft_out = peak_ch[0];
  assign rht_out = peak_ch[1];
`endif

  assign peak_vld_d = smpl_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) peak_vld_q <= 1'b0;
    else     peak_vld_q <= peak_vld_d;
  end

  assign peak_vld = peak_vld_q;
endmodule

// File: tb/tb_audio_peak_meter.sv
module tb_audio_peak_meter;
  logic        clk = 1'b0;
  logic        rst;
  logic        smpl_vld;
  logic [15:0] lft_in, rht_in;
  logic [15:0] lft_out, rht_out;
  logic        peak_vld;

  int errors = 0;
  int checks = 0;

  audio_peak_meter #(.HOLD_SAMPLES(4), .DECAY_STEP(16'h1000)) dut (
    .clk(clk), .rst(rst), .smpl_vld(smpl_vld),
    .lft_in(lft_in), .rht_in(rht_in),
    .lft_out(lft_out), .rht_out(rht_out), .peak_vld(peak_vld)
  );

  always #5 clk = ~clk;

  // One strobe; returns on the following falling edge where outputs are settled.
  task automatic strobe(input logic [15:0] l, input logic [15:0] r);
    @(negedge clk);
    smpl_vld = 1'b1; lft_in = l; rht_in = r;
    @(negedge clk);
    smpl_vld = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; smpl_vld = 1'b0; lft_in = '0; rht_in = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; smpl_vld = 1'b0; lft_in = '0; rht_in = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({lft_out, rht_out, peak_vld} !== 33'h0) begin
      errors++; $display("FAIL reset_init got l=%h r=%h v=%b want 0", lft_out, rht_out, peak_vld);
    end
    rst = 1'b0;
    strobe(16'h4000, 16'h0000);
    checks++;
    if (lft_out !== 16'h8000) begin
      errors++; $display("FAIL reset_pre got %h want 8000", lft_out);
    end
    // Reset asserted mid-stream with a coincident strobe.
    @(negedge clk);
    smpl_vld = 1'b1; lft_in = 16'h4000; rst = 1'b1;
    #1;
    checks++;
    if ({lft_out, rht_out, peak_vld} !== 33'h0) begin
      errors++; $display("FAIL reset_async got l=%h r=%h v=%b want 0", lft_out, rht_out, peak_vld);
    end
    @(negedge clk);
    rst = 1'b0; smpl_vld = 1'b0; lft_in = '0;
    checks++;
    if ({lft_out, peak_vld} !== 17'h0) begin
      errors++; $display("FAIL reset_discard got l=%h v=%b want 0", lft_out, peak_vld);
    end
    strobe(16'h0000, 16'h0000);
    checks++;
    if ({lft_out, rht_out, peak_vld} !== {32'h0, 1'b1}) begin
      errors++; $display("FAIL reset_first got l=%h r=%h v=%b want 0 0 1", lft_out, rht_out, peak_vld);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    strobe(16'h8000, 16'h7FFF);
    checks++;
    if ({lft_out, rht_out} !== {16'hFFFE, 16'hFFFE}) begin
      errors++; $display("FAIL sat_full got l=%h r=%h want fffe fffe", lft_out, rht_out);
    end
    strobe(16'hFFFF, 16'h0000);
    checks++;
    if ({lft_out, rht_out} !== {16'hFFFE, 16'hFFFE}) begin
      errors++; $display("FAIL sat_hold got l=%h r=%h want fffe fffe", lft_out, rht_out);
    end
    strobe(16'h0001, 16'h0000);
    checks++;
    if (lft_out !== 16'hFFFE) begin
      errors++; $display("FAIL sat_small got %h want fffe", lft_out);
    end
    // Magnitude path on a fresh channel: -1 -> 2.
    do_reset();
    strobe(16'hFFFF, 16'hC000);
    checks++;
    if ({lft_out, rht_out} !== {16'h0002, 16'h8000}) begin
      errors++; $display("FAIL sat_neg got l=%h r=%h want 0002 8000", lft_out, rht_out);
    end
  endtask

  task automatic test_hold_decay();
    logic [15:0] exp;
    do_reset();
    strobe(16'h4000, 16'h0000);
    checks++;
    if (lft_out !== 16'h8000) begin
      errors++; $display("FAIL hd_capture got %h want 8000", lft_out);
    end
    for (int i = 0; i < 5; i++) begin
      strobe(16'h0000, 16'h0000);
      checks++;
      if (lft_out !== 16'h8000) begin
        errors++; $display("FAIL hd_hold%0d got %h want 8000", i, lft_out);
      end
    end
    exp = 16'h8000;
    for (int i = 0; i < 8; i++) begin
      exp = exp - 16'h1000;
      strobe(16'h0000, 16'h0000);
      checks++;
      if (lft_out !== exp || rht_out !== 16'h0) begin
        errors++; $display("FAIL hd_decay%0d got l=%h r=%h want %h 0000", i, lft_out, rht_out, exp);
      end
    end
    strobe(16'h0000, 16'h0000);
    checks++;
    if (lft_out !== 16'h0) begin
      errors++; $display("FAIL hd_idle got %h want 0000", lft_out);
    end
    strobe(16'h0008, 16'h0000);
    checks++;
    if (lft_out !== 16'h0010) begin
      errors++; $display("FAIL hd_recapture got %h want 0010", lft_out);
    end
  endtask

  task automatic test_retrigger();
    do_reset();
    strobe(16'h4000, 16'h0000);
    repeat (5) strobe(16'h0000, 16'h0000);
    strobe(16'h0000, 16'h0000);
    strobe(16'h0000, 16'h0000);
    checks++;
    if (lft_out !== 16'h6000) begin
      errors++; $display("FAIL rt_pre got %h want 6000", lft_out);
    end
    strobe(16'h2C00, 16'h0000);
    checks++;
    if (lft_out !== 16'h5800) begin
      errors++; $display("FAIL rt_capture got %h want 5800", lft_out);
    end
    for (int i = 0; i < 5; i++) begin
      strobe(16'h0000, 16'h0000);
      checks++;
      if (lft_out !== 16'h5800) begin
        errors++; $display("FAIL rt_hold%0d got %h want 5800", i, lft_out);
      end
    end
    strobe(16'h0000, 16'h0000);
    checks++;
    if (lft_out !== 16'h4800) begin
      errors++; $display("FAIL rt_decay got %h want 4800", lft_out);
    end
  endtask

  // Continues from the decaying state left by test_retrigger (peak 4800).
  task automatic test_gating();
    int bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (lft_out !== 16'h4800 || peak_vld !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL gate_frozen got %0d bad cycles want 0", bad);
    end
    strobe(16'h0000, 16'h0000);
    checks++;
    if (lft_out !== 16'h3800 || peak_vld !== 1'b1) begin
      errors++; $display("FAIL gate_resume got l=%h v=%b want 3800 1", lft_out, peak_vld);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vin [5];
    logic [15:0] vexp [5];
    vin  = '{16'h1000, 16'h2000, 16'h3000, 16'h0000, 16'h7FFF};
    vexp = '{16'h2000, 16'h4000, 16'h6000, 16'h6000, 16'hFFFE};
    do_reset();
    @(negedge clk);
    smpl_vld = 1'b1; lft_in = vin[0]; rht_in = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (lft_out !== vexp[i] || peak_vld !== 1'b1) begin
        errors++; $display("FAIL b2b%0d got l=%h v=%b want %h 1", i, lft_out, peak_vld, vexp[i]);
      end
      if (i < 4) lft_in = vin[i+1];
      else       smpl_vld = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (peak_vld !== 1'b0) begin
      errors++; $display("FAIL b2b_end got v=%b want 0", peak_vld);
    end
  endtask

  task automatic test_channels();
    do_reset();
    strobe(16'h0000, 16'h2000);
    checks++;
`ifdef PEAK_STEREO_LINK_EN
    if (lft_out !== 16'h4000 || rht_out !== 16'h4000) begin
      errors++; $display("FAIL link got l=%h r=%h want 4000 4000", lft_out, rht_out);
    end
`else
    if (lft_out !== 16'h0000 || rht_out !== 16'h4000) begin
      errors++; $display("FAIL indep got l=%h r=%h want 0000 4000", lft_out, rht_out);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_saturation();
    test_hold_decay();
    test_retrigger();
    test_gating();
    test_back_to_back();
    test_channels();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
